// File: rtl/axis_tx_arbiter.sv
// axis_tx_arbiter: packet-locked round-robin arbiter that shares
// the 64-bit AXI-Stream TX path into the MAC between NUM_SRC sources.
module axis_tx_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [64*NUM_SRC-1:0] s_tdata,
  input  logic [8*NUM_SRC-1:0]  s_tkeep,
  input  logic [NUM_SRC-1:0]    s_tvalid,
  input  logic [NUM_SRC-1:0]    s_tlast,
  output logic [NUM_SRC-1:0]    s_tready,
  output logic [63:0]           m_tdata,
  output logic [7:0]            m_tkeep,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic [IDX_W-1:0]      m_tid,
  output logic [15:0]           pkt_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] winner;
  logic             found;
  logic             last_xfer;

  // Search upward from last_grant+1 with wrap; first valid wins.
  always_comb begin
    int j;
    winner = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      j = (int'(last_grant) + k) % NUM_SRC;
      if (!found && s_tvalid[j]) begin
        winner = IDX_W'(j);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    if (state == BUSY) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (grant == IDX_W'(i)) begin
          m_tdata     = s_tdata[64*i +: 64];
          m_tkeep     = s_tkeep[8*i +: 8];
          m_tvalid    = s_tvalid[i];
          m_tlast     = s_tlast[i];
          s_tready[i] = m_tready;
        end
      end
    end
  end

  assign last_xfer = m_tvalid && m_tready && m_tlast;
  assign m_tid     = grant;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IDX_W'(NUM_SRC - 1);
      pkt_cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            grant <= winner;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (last_xfer) begin
            state      <= IDLE;
            last_grant <= grant;
            pkt_cnt    <= pkt_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_tx_arbiter.sv
// tb_axis_tx_arbiter: table-driven cycle vectors plus directed
// sequences for counter wrap and asynchronous reset mid-packet.
module tb_axis_tx_arbiter;

  logic         clk = 1'b0;
  logic         resetn;
  logic [127:0] s_tdata;
  logic [15:0]  s_tkeep;
  logic [1:0]   s_tvalid;
  logic [1:0]   s_tlast;
  logic [1:0]   s_tready;
  logic [63:0]  m_tdata;
  logic [7:0]   m_tkeep;
  logic         m_tvalid;
  logic         m_tlast;
  logic         m_tready;
  logic [0:0]   m_tid;
  logic [15:0]  pkt_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_tx_arbiter #(.NUM_SRC(2)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .s_tdata  (s_tdata),
    .s_tkeep  (s_tkeep),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tready (m_tready),
    .m_tid    (m_tid),
    .pkt_cnt  (pkt_cnt)
  );

  typedef struct {
    logic [1:0]  vld;
    logic [1:0]  lst;
    logic        rdy;
    logic        ev;
    logic        etid;
    logic        el;
    logic [1:0]  erdy;
    int          esrc;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vq[$];

  function automatic logic [63:0] src_data(int src, int k);
    return {src == 0 ? 32'hA0A0_0000 : 32'hB1B1_0000, 32'(k)};
  endfunction

  function automatic logic [7:0] src_keep(int src);
    return src == 0 ? 8'hFF : 8'h0F;
  endfunction

  function automatic vec_t mk(logic [1:0] vld, logic [1:0] lst,
                              logic rdy, logic ev, logic etid,
                              logic el, logic [1:0] erdy,
                              int esrc, logic [15:0] ecnt);
    vec_t v;
    v.vld  = vld;
    v.lst  = lst;
    v.rdy  = rdy;
    v.ev   = ev;
    v.etid = etid;
    v.el   = el;
    v.erdy = erdy;
    v.esrc = esrc;
    v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(logic [1:0] vld, logic [1:0] lst,
                       logic rdy, int k);
    s_tvalid = vld;
    s_tlast  = lst;
    m_tready = rdy;
    s_tdata  = {src_data(1, k), src_data(0, k)};
    s_tkeep  = {src_keep(1), src_keep(0)};
  endtask

  task automatic chk_out(string tag, logic ev, logic etid, logic el,
                         logic [1:0] erdy, int esrc, logic [15:0] ecnt,
                         int k);
    logic [63:0] ed;
    logic [7:0]  ek;
    ed = (esrc < 0) ? 64'd0 : src_data(esrc, k);
    ek = (esrc < 0) ? 8'd0 : src_keep(esrc);
    chk({tag, ".m_tvalid"}, 64'(m_tvalid), 64'(ev));
    chk({tag, ".m_tid"}, 64'(m_tid), 64'(etid));
    chk({tag, ".m_tlast"}, 64'(m_tlast), 64'(el));
    chk({tag, ".s_tready"}, 64'(s_tready), 64'(erdy));
    chk({tag, ".m_tdata"}, m_tdata, ed);
    chk({tag, ".m_tkeep"}, 64'(m_tkeep), 64'(ek));
    chk({tag, ".pkt_cnt"}, 64'(pkt_cnt), 64'(ecnt));
  endtask

  task automatic send1(int src);
    logic [1:0] b;
    b = 2'(1 << src);
    @(negedge clk);
    drive(b, b, 1'b1, 900);
    @(negedge clk);
    @(negedge clk);
    drive(2'b00, 2'b00, 1'b1, 901);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    drive(2'b00, 2'b00, 1'b0, 0);
    #1;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 2'b00, -1, 16'd0, 0);

    // single requester: src0, 3 beats, then bubble
    vq.push_back(mk(2'b01, 2'b00, 1, 0, 0, 0, 2'b00, -1, 0));
    vq.push_back(mk(2'b01, 2'b00, 1, 1, 0, 0, 2'b01, 0, 0));
    vq.push_back(mk(2'b01, 2'b00, 1, 1, 0, 0, 2'b01, 0, 0));
    vq.push_back(mk(2'b01, 2'b01, 1, 1, 0, 1, 2'b01, 0, 0));
    vq.push_back(mk(2'b00, 2'b00, 1, 0, 0, 0, 2'b00, -1, 1));
    // simultaneous 2-beat packets, round-robin src1,src0,src1
    vq.push_back(mk(2'b11, 2'b00, 1, 0, 0, 0, 2'b00, -1, 1));
    vq.push_back(mk(2'b11, 2'b00, 1, 1, 1, 0, 2'b10, 1, 1));
    vq.push_back(mk(2'b11, 2'b10, 1, 1, 1, 1, 2'b10, 1, 1));
    vq.push_back(mk(2'b11, 2'b00, 1, 0, 1, 0, 2'b00, -1, 2));
    vq.push_back(mk(2'b11, 2'b00, 1, 1, 0, 0, 2'b01, 0, 2));
    vq.push_back(mk(2'b11, 2'b01, 1, 1, 0, 1, 2'b01, 0, 2));
    vq.push_back(mk(2'b11, 2'b00, 1, 0, 0, 0, 2'b00, -1, 3));
    vq.push_back(mk(2'b11, 2'b00, 1, 1, 1, 0, 2'b10, 1, 3));
    vq.push_back(mk(2'b11, 2'b10, 1, 1, 1, 1, 2'b10, 1, 3));
    vq.push_back(mk(2'b00, 2'b00, 1, 0, 1, 0, 2'b00, -1, 4));
    // backpressure: src1 4 beats, m_tready 1,0,0,1,1,0,1
    vq.push_back(mk(2'b10, 2'b00, 1, 0, 1, 0, 2'b00, -1, 4));
    vq.push_back(mk(2'b10, 2'b00, 1, 1, 1, 0, 2'b10, 1, 4));
    vq.push_back(mk(2'b10, 2'b00, 0, 1, 1, 0, 2'b00, 1, 4));
    vq.push_back(mk(2'b10, 2'b00, 0, 1, 1, 0, 2'b00, 1, 4));
    vq.push_back(mk(2'b10, 2'b00, 1, 1, 1, 0, 2'b10, 1, 4));
    vq.push_back(mk(2'b10, 2'b00, 1, 1, 1, 0, 2'b10, 1, 4));
    vq.push_back(mk(2'b10, 2'b10, 0, 1, 1, 1, 2'b00, 1, 4));
    vq.push_back(mk(2'b10, 2'b10, 1, 1, 1, 1, 2'b10, 1, 4));
    vq.push_back(mk(2'b00, 2'b00, 1, 0, 1, 0, 2'b00, -1, 5));
    // no interleave: src0 5 beats with 2-cycle stall, src1 waits
    vq.push_back(mk(2'b01, 2'b00, 1, 0, 1, 0, 2'b00, -1, 5));
    vq.push_back(mk(2'b01, 2'b00, 1, 1, 0, 0, 2'b01, 0, 5));
    vq.push_back(mk(2'b11, 2'b00, 1, 1, 0, 0, 2'b01, 0, 5));
    vq.push_back(mk(2'b10, 2'b00, 1, 0, 0, 0, 2'b01, 0, 5));
    vq.push_back(mk(2'b10, 2'b00, 1, 0, 0, 0, 2'b01, 0, 5));
    vq.push_back(mk(2'b11, 2'b00, 1, 1, 0, 0, 2'b01, 0, 5));
    vq.push_back(mk(2'b11, 2'b00, 1, 1, 0, 0, 2'b01, 0, 5));
    vq.push_back(mk(2'b11, 2'b01, 1, 1, 0, 1, 2'b01, 0, 5));
    vq.push_back(mk(2'b10, 2'b00, 1, 0, 0, 0, 2'b00, -1, 6));
    vq.push_back(mk(2'b10, 2'b10, 1, 1, 1, 1, 2'b10, 1, 6));
    vq.push_back(mk(2'b00, 2'b00, 1, 0, 1, 0, 2'b00, -1, 7));

    @(negedge clk);
    resetn = 1'b1;
    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].vld, vq[i].lst, vq[i].rdy, i);
      #1;
      chk_out($sformatf("vec%0d", i), vq[i].ev, vq[i].etid,
              vq[i].el, vq[i].erdy, vq[i].esrc, vq[i].ecnt, i);
    end

    // counter wrap: preload near the top, then single-beat packets
    @(negedge clk);
    force dut.pkt_cnt = 16'hFFFE;
    #1;
    release dut.pkt_cnt;
    send1(0);
    chk("wrap.ffff", 64'(pkt_cnt), 64'hFFFF);
    send1(1);
    chk("wrap.0000", 64'(pkt_cnt), 64'h0000);
    send1(0);
    chk("wrap.0001", 64'(pkt_cnt), 64'h0001);

    // reset mid-packet on src1 beat 2, both sources requesting
    @(negedge clk);
    drive(2'b10, 2'b00, 1'b1, 50);
    @(negedge clk);
    drive(2'b10, 2'b00, 1'b1, 51);
    #1;
    chk_out("rst.beat1", 1'b1, 1'b1, 1'b0, 2'b10, 1, 16'd1, 51);
    @(negedge clk);
    drive(2'b11, 2'b00, 1'b1, 52);
    #2;
    resetn = 1'b0;
    #1;
    chk_out("rst.async", 1'b0, 1'b0, 1'b0, 2'b00, -1, 16'd0, 52);
    @(negedge clk);
    resetn = 1'b1;
    drive(2'b11, 2'b00, 1'b1, 53);
    #1;
    chk_out("rst.idle", 1'b0, 1'b0, 1'b0, 2'b00, -1, 16'd0, 53);
    @(negedge clk);
    drive(2'b11, 2'b00, 1'b1, 54);
    #1;
    chk_out("rst.src0b1", 1'b1, 1'b0, 1'b0, 2'b01, 0, 16'd0, 54);
    @(negedge clk);
    drive(2'b11, 2'b11, 1'b1, 55);
    #1;
    chk_out("rst.src0b2", 1'b1, 1'b0, 1'b1, 2'b01, 0, 16'd0, 55);
    @(negedge clk);
    drive(2'b11, 2'b00, 1'b1, 56);
    #1;
    chk_out("rst.bubble", 1'b0, 1'b0, 1'b0, 2'b00, -1, 16'd1, 56);
    @(negedge clk);
    drive(2'b11, 2'b00, 1'b1, 57);
    #1;
    chk_out("rst.src1", 1'b1, 1'b1, 1'b0, 2'b10, 1, 16'd1, 57);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
